// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by TL-UL devices: field widths, opcodes and the
// host-to-device / device-to-host channel structs.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_m_op;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_m_op;

  typedef struct packed {
    logic                a_valid;
    tl_a_m_op            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_m_op            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with occupancy counter. A push is dropped when full and a
// pop is ignored when empty; push and pop in the same cycle keep occupancy.
module prim_fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic [CntW-1:0]  cnt;
  logic             push, pop;

  assign full_o  = (cnt == CntW'(Depth));
  assign empty_o = (cnt == '0);
  assign push    = wvalid_i && !full_o;
  assign pop     = rready_i && !empty_o;
  assign rdata_o = mem[rptr];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Storage: payload only, no reset needed since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata_i;
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop)      cnt <= cnt + CntW'(1);
      else if (pop && !push) cnt <= cnt - CntW'(1);
    end
  end

endmodule

// File: rtl/tlul_adapter_sram.sv
// TL-UL device adapter driving a single-port, fixed-latency SRAM port.
// Optional request checking is enabled by defining TLUL_ADAPTER_SRAM_ERR_CHECK_EN.
//
// Handshakes: a channel beat transfers on a cycle where valid && ready are
// both high. The A channel is accepted when a_valid && a_ready; forwarded
// requests complete with req_o && gnt_i in that same cycle. The D channel
// holds every field stable while d_valid && !d_ready.
module tlul_adapter_sram
  import tlul_pkg::*;
#(
  parameter int SramAw      = 12,
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [TL_DW-1:0]  wdata_o,
  output logic [TL_DW-1:0]  wmask_o,
  input  logic              rvalid_i,
  input  logic [TL_DW-1:0]  rdata_i
);

  typedef struct packed {
    tl_d_m_op          opcode;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
`ifdef TLUL_ADAPTER_SRAM_ERR_CHECK_EN
    logic              error;
`endif
  } trk_t;

  trk_t             trk_in, trk_head;
  logic             trk_full, trk_empty, trk_pop;
  logic [TL_DW-1:0] rd_head;
  logic             rd_full, rd_empty, rd_pop;
  logic             a_err, a_ready, accept, rd_pend;
  logic             head_read, head_err, d_valid;

`ifdef TLUL_ADAPTER_SRAM_ERR_CHECK_EN
  logic [TL_DBW-1:0] win;
  logic              misalign, size_bad;

  // Request legality: opcode, alignment, mask within the size window.
  always_comb begin
    win      = '0;
    misalign = 1'b0;
    size_bad = 1'b0;
    case (tl_i.a_size)
      2'd0: win = 4'b0001 << tl_i.a_address[1:0];
      2'd1: begin
        win      = 4'b0011 << tl_i.a_address[1:0];
        misalign = tl_i.a_address[0];
      end
      2'd2: begin
        win      = 4'b1111;
        misalign = |tl_i.a_address[1:0];
      end
      default: size_bad = 1'b1;
    endcase
    a_err = !(tl_i.a_opcode inside {PutFullData, PutPartialData, Get}) ||
            misalign || size_bad || (|(tl_i.a_mask & ~win)) ||
            ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != win));
  end
  assign head_err = trk_head.error;
`else
  assign a_err    = 1'b0;
  assign head_err = 1'b0;
`endif

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address, rd_full};

  // Full blocks acceptance even if a response pops this cycle.
  assign a_ready = !trk_full && (a_err || gnt_i);
  assign accept  = tl_i.a_valid && a_ready;
  assign req_o   = tl_i.a_valid && !trk_full && !a_err;
  assign we_o    = (tl_i.a_opcode != Get);
  assign addr_o  = tl_i.a_address[SramAw+1:2];
  assign wdata_o = we_o ? tl_i.a_data : '0;

  // Byte-enable mask to bit-enable mask.
  always_comb begin
    wmask_o = '0;
    for (int i = 0; i < TL_DBW; i++) wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
  end

  // Tracking entry captured on every accepted request.
  always_comb begin
    trk_in        = '0;
    trk_in.opcode = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
    trk_in.size   = tl_i.a_size;
    trk_in.source = tl_i.a_source;
`ifdef TLUL_ADAPTER_SRAM_ERR_CHECK_EN
    trk_in.error  = a_err;
`endif
  end

  // Marks the one cycle in which the memory returns data for a granted read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_pend <= 1'b0;
    else         rd_pend <= req_o && gnt_i && !we_o;
  end

  assign head_read = (trk_head.opcode == AccessAckData);
  assign d_valid   = !trk_empty && (!head_read || head_err || !rd_empty);
  assign trk_pop   = d_valid && tl_i.d_ready;
  assign rd_pop    = trk_pop && head_read && !head_err;

  // D-channel response built from the tracking head and read-data head.
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = trk_head.opcode;
    tl_o.d_size   = trk_head.size;
    tl_o.d_source = trk_head.source;
    tl_o.d_error  = head_err;
    tl_o.a_ready  = a_ready;
    if (head_read) tl_o.d_data = head_err ? '1 : rd_head;
  end

  prim_fifo_sync #(.Width($bits(trk_t)), .Depth(Outstanding)) u_trk_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (accept),
    .wdata_i  (trk_in),
    .rready_i (trk_pop),
    .rdata_o  (trk_head),
    .full_o   (trk_full),
    .empty_o  (trk_empty)
  );

  prim_fifo_sync #(.Width(TL_DW), .Depth(Outstanding)) u_rd_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (rvalid_i && rd_pend),
    .wdata_i  (rdata_i),
    .rready_i (rd_pop),
    .rdata_o  (rd_head),
    .full_o   (rd_full),
    .empty_o  (rd_empty)
  );

endmodule

// File: doc/tlul_adapter_sram.md
# tlul_adapter_sram

Device-side TL-UL adapter that terminates a `tl_h2d_t`/`tl_d2h_t` link and drives a single-port, fixed-latency SRAM-style memory interface. It sits directly downstream of the TL-UL host/crossbar and is the consumer of every A-channel request the bus produces, returning D-channel responses in order. Up to `Outstanding` requests may be in flight; response metadata and read data are buffered internally.

## Interface
- `SramAw`, 12, word-address width of the memory port
- `Outstanding`, 2, maximum accepted-but-unanswered requests (depth of both internal FIFOs, ≥1)

- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `tl_i`  in  `tl_h2d_t`  A-channel request plus `d_ready`
- `tl_o`  out  `tl_d2h_t`  D-channel response plus `a_ready`
- `req_o`  out  1  memory request
- `gnt_i`  in  1  memory grant, same cycle as `req_o`
- `we_o`  out  1  1 = write, 0 = read
- `addr_o`  out  `SramAw`  word address = `a_address[SramAw+1:2]`; upper bits ignored
- `wdata_o`  out  `TL_DW`  `a_data` on writes, 0 on reads
- `wmask_o`  out  `TL_DW`  each `a_mask` bit replicated ×8
- `rvalid_i`  in  1  read data valid, exactly 1 cycle after a granted read
- `rdata_i`  in  `TL_DW`  read data

## Operation
- Request is forwarded (`req_o`=1) when `a_valid` && tracking FIFO not full && request not errored.
- `a_ready` = !full && (errored ? 1 : `gnt_i`). Accept = `a_valid && a_ready`.
- On accept, tracking FIFO pushes {d_opcode, size, source, error}. `Get` maps to AccessAckData; `PutFullData`/`PutPartialData` map to AccessAck.
- On a granted read, the `rd_pend` flag is set for 1 cycle. `rvalid_i` && `rd_pend` pushes `rdata_i` into the read-data FIFO. `rvalid_i` without `rd_pend` is ignored.
- `d_valid` is 1 when the tracking head is present and either:
  - the head is a write or errored entry, or
  - the head is a read and the read-data FIFO is non-empty.
- On `d_valid && d_ready`, pop the tracking FIFO, and pop the read-data FIFO if the head is a non-errored read.
- D-channel fields:
  - `d_data`: rdata for reads; 0 for writes; all-ones for errored Get.
  - `d_size`/`d_source`: echoed from the request.
  - `d_param`, `d_sink`: 0.
- Responses are strictly in request order.

## Timing
- Reset: both FIFOs empty, `rd_pend`=0, `d_valid`=0. `req_o`, `a_ready` are combinational; they follow the inputs, with `a_ready`=`gnt_i` when `a_valid` and not errored.
- Minimum write latency: accept in cycle N, `d_valid` in N+1. Minimum read latency: accept in N, `rvalid_i` in N+1, `d_valid` in N+2.
- Full: `a_ready`=0 even if a pop occurs the same cycle. There is no `d_ready`→`a_ready` combinational path, so `Outstanding`=1 gives a 1-request-per-2-cycles maximum.
- Read-data FIFO can never overflow: its occupancy is at most the number of outstanding reads, which is at most `Outstanding`.
- Simultaneous push and pop on either FIFO is legal when not full; occupancy is unchanged.
- Reset mid-operation: all in-flight transactions are dropped. `rvalid_i` arriving after reset is ignored because `rd_pend`=0.
- `tl_o` fields are stable while `d_valid && !d_ready`.

## Configuration
- `TLUL_ADAPTER_SRAM_ERR_CHECK_EN` defined — a request is errored when any of these holds:
  - opcode ∉ {PutFullData, PutPartialData, Get};
  - address is misaligned to `2^a_size`;
  - `a_mask` has bits outside the size window;
  - PutFullData mask ≠ the full size window.

  Errored requests never assert `req_o`, are accepted without `gnt_i`, and respond with `d_error`=1.
- Macro undefined: no checks. Every request is forwarded, `d_error` is constant 0, and the error field is not stored.

## Structure
- Uses `tlul_pkg` types (`tl_h2d_t`, `tl_d2h_t`, `tl_a_m_op`, `tl_d_m_op`, `TL_*` widths). No package additions.
- The tracking-entry struct is local to the module.
- One sub-module: `prim_fifo_sync` (depth `Outstanding`, parameterised width, async active-low reset), instantiated twice: tracking FIFO and read-data FIFO.

## Test plan
- Get addr 0x10, `gnt_i`=1, `rdata_i`=0xDEADBEEF next cycle → `addr_o`=4, AccessAckData with `d_data`=0xDEADBEEF at N+2, `d_source` echoed.
- PutPartialData mask 0b0101, data 0x11223344 → `wmask_o`=0x00FF00FF, `we_o`=1, AccessAck at N+1, `d_error`=0.
- `Outstanding`=2, three back-to-back Gets, `d_ready`=0 → the third is stalled (`a_ready`=0); releasing `d_ready` returns responses in order.
- `gnt_i`=0 for 3 cycles → `a_ready`=0, nothing is pushed; the request is accepted on the first cycle `gnt_i`=1.
- With the macro: Get size 2 at addr 0x2 → `req_o`=0, accepted, `d_error`=1, `d_data`=0xFFFFFFFF. Without the macro: the same request is forwarded with `d_error`=0.
- Assert `rst_ni` with a read granted and the response pending → after release `d_valid`=0, and a stray `rvalid_i` produces no response.
